level_sequencer: RTL
====================

Name: level_sequencer

Overview:
Top-level game flow controller for the level blocks. Sequences title → level load → play → result display → next level / retry / game over. Drives the level-select mux and the active-low level reset. Tracks lives, and consumes the selected level's win/lose flags and a per-frame tick from the VGA timing block.

Parameters:
NUM_LEVELS, 3, number of levels; valid range 1..4.
START_LIVES, 3, lives at game start; valid range 1..15.
LOAD_CYCLES, 4, number of cycles level_reset_n is held low in LOAD; minimum 1.
GUARD_CYCLES, 2, number of PLAY cycles after LOAD during which win/lose are ignored.
HOLD_FRAMES, 120, number of frame_tick pulses spent in WIN_HOLD or LOSE_HOLD.

Ports:
vga_clock  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start_button  in  1  debounced level, active-high; acted on at rising edge only.
frame_tick  in  1  one-cycle pulse per video frame.
level_win  in  1  win flag from the selected level.
level_lose  in  1  lose flag from the selected level.
skip_button  in  1  debug level skip; only used with SEQ_SKIP_EN.
level_sel  out  2  index of the active level, 0..NUM_LEVELS-1.
level_reset_n  out  1  active-low reset to the level blocks.
lives  out  4  remaining lives.
state  out  3  encoded FSM state.
playing  out  1  high in PLAY; gates player input.
game_over  out  1  high in OVER.
game_won  out  1  high in DONE.

Behaviour:
- All outputs are registered. Reset values: state=IDLE, level_sel=0, lives=START_LIVES, level_reset_n=0, playing=0, game_over=0, game_won=0.
- start_button edge detect: register the previous value; start_edge = start_button & ~start_q. start_q resets to 1, so a button held through reset does not trigger a start.
- State encoding:
  - IDLE=0: level_reset_n=0. On start_edge: level_sel=0, lives=START_LIVES, go to LOAD.
  - LOAD=1: level_reset_n=0. The counter counts LOAD_CYCLES cycles, then goes to PLAY. level_reset_n goes high on the cycle state becomes PLAY.
  - PLAY=2: playing=1. A guard counter ignores win/lose for the first GUARD_CYCLES cycles. After that, win and lose are sampled every cycle:
    - level_win → WIN_HOLD.
    - level_lose alone → LOSE_HOLD.
    - Both asserted in the same cycle: win has priority.
  - WIN_HOLD=3: playing=0; the level is held out of reset so its display stays frozen. Count HOLD_FRAMES frame_tick pulses. Then:
    - If level_sel==NUM_LEVELS-1 → DONE.
    - Otherwise level_sel+1 → LOAD.
  - LOSE_HOLD=4: count HOLD_FRAMES frame_tick pulses. Then lives is decremented:
    - If the new value is 0 → OVER.
    - Otherwise → LOAD with the same level_sel.
  - OVER=5: game_over=1, level_reset_n=0. On start_edge → IDLE.
  - DONE=6: game_won=1, level_reset_n=0. On start_edge → IDLE.
- The frame counter is 8 bits minimum and clears on every state entry. frame_tick arriving in the same cycle as state entry is not counted.
- lives never wraps below 0. It only changes in LOSE_HOLD exit and IDLE start.
- start_edge is ignored in LOAD, PLAY, WIN_HOLD and LOSE_HOLD.
- Reset asserted mid-operation forces the reset values immediately and asynchronously. level_reset_n is low during reset.
- Unused state 7 → IDLE on the next clock.

Optional Feature:
SEQ_SKIP_EN.
- Defined: a rising edge of skip_button in PLAY (after the guard) behaves as level_win, entering WIN_HOLD. Priority is lose < skip < win.
- Undefined: skip_button is unused and has no logic or edge register.

Test Plan:
1. Assert reset 3 cycles, release; hold start=0 → state=0, lives=3, level_reset_n=0, level_sel=0.
2. Pulse start; 4 cycles later → state=2, level_reset_n=1. Assert win at PLAY cycle 0 and 1 → ignored. Assert win at cycle 2 → state=3. After 120 frame_ticks → LOAD, level_sel=1.
3. Lose in PLAY three times on level 1 → lives 2, then 1, then 0; state=5 with game_over=1. Pulse start → state=0.
4. Win levels 0, 1, 2 in turn → state=6, game_won=1, level_sel stays 2.
5. Assert win and lose in the same PLAY cycle → WIN_HOLD, lives unchanged at 3.
6. Assert reset during LOSE_HOLD at frame 60 → state=0, lives=3 immediately, without waiting for a clock edge. With SEQ_SKIP_EN defined, a skip edge in PLAY → state=3.

Source files
------------

// File: rtl/level_sequencer.sv
// Game flow controller: title, level load, play, result hold, next level / retry / game over.
// Define SEQ_SKIP_EN to let a skip_button rising edge in PLAY count as a level win.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | title screen, levels held in reset, waiting for start
// LOAD      | level_reset_n held low for LOAD_CYCLES cycles
// PLAY      | level running, win/lose sampled once the guard expires
// WIN_HOLD  | level frozen for HOLD_FRAMES frames, then next level
// LOSE_HOLD | level frozen for HOLD_FRAMES frames, then a life is lost
// OVER      | no lives left, waiting for start
// DONE      | last level won, waiting for start
module level_sequencer #(
    parameter int NUM_LEVELS   = 3,
    parameter int START_LIVES  = 3,
    parameter int LOAD_CYCLES  = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       start_button,
    input  logic       frame_tick,
    input  logic       level_win,
    input  logic       level_lose,
    input  logic       skip_button,
    output logic [1:0] level_sel,
    output logic       level_reset_n,
    output logic [3:0] lives,
    output logic [2:0] state,
    output logic       playing,
    output logic       game_over,
    output logic       game_won
);

    localparam int CNT_MAX = (LOAD_CYCLES > GUARD_CYCLES) ? LOAD_CYCLES : GUARD_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int FW      = (HOLD_FRAMES > 255) ? $clog2(HOLD_FRAMES + 1) : 8;

    localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_INIT = CW'(GUARD_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(HOLD_FRAMES - 1);
    localparam logic [1:0]    LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(START_LIVES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PLAY      = 3'd2,
        S_WIN_HOLD  = 3'd3,
        S_LOSE_HOLD = 3'd4,
        S_OVER      = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    logic          start_q;
    logic          start_edge;
    logic          advance;
    logic          frame_done;
    logic [CW-1:0] cyc_cnt;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    flags_q;

    assign start_edge = start_button & ~start_q;
    assign frame_done = frame_tick && (frame_cnt == FRAME_LAST);
    assign {level_reset_n, playing, game_over, game_won} = flags_q;

`ifdef SEQ_SKIP_EN
    logic skip_q;
    logic skip_edge;

    assign skip_edge = skip_button & ~skip_q;
    assign advance   = level_win | skip_edge;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset)
            skip_q <= 1'b1;
        else
            skip_q <= skip_button;
    end
`else
    logic unused_skip;

    assign unused_skip = skip_button;
    assign advance     = level_win;
`endif

    // Output flags {level_reset_n, playing, game_over, game_won} for the state being entered.
    function automatic logic [3:0] flags_for(state_t s);
        logic [3:0] f;
        f = 4'b0000;
        case (s)
            S_PLAY:                  f = 4'b1100;
            S_WIN_HOLD, S_LOSE_HOLD: f = 4'b1000;
            S_OVER:                  f = 4'b0010;
            S_DONE:                  f = 4'b0001;
            default:                 f = 4'b0000;
        endcase
        return f;
    endfunction

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            level_sel <= '0;
            lives     <= LIVES_INIT;
            flags_q   <= 4'b0000;
            start_q   <= 1'b1;
            cyc_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            start_q <= start_button;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        level_sel <= '0;
                        lives     <= LIVES_INIT;
                        cyc_cnt   <= LOAD_INIT;
                        frame_cnt <= '0;
                        state     <= S_LOAD;
                        flags_q   <= flags_for(S_LOAD);
                    end
                end
                S_LOAD: begin
                    if (cyc_cnt == '0) begin
                        cyc_cnt   <= GUARD_INIT;
                        frame_cnt <= '0;
                        state     <= S_PLAY;
                        flags_q   <= flags_for(S_PLAY);
                    end else begin
                        cyc_cnt <= cyc_cnt - CW'(1);
                    end
                end
                S_PLAY: begin
                    // Guard lets the freshly released level settle before its flags are trusted.
                    if (cyc_cnt != '0) begin
                        cyc_cnt <= cyc_cnt - CW'(1);
                    end else if (advance) begin
                        frame_cnt <= '0;
                        state     <= S_WIN_HOLD;
                        flags_q   <= flags_for(S_WIN_HOLD);
                    end else if (level_lose) begin
                        frame_cnt <= '0;
                        state     <= S_LOSE_HOLD;
                        flags_q   <= flags_for(S_LOSE_HOLD);
                    end
                end
                S_WIN_HOLD: begin
                    if (frame_done) begin
                        frame_cnt <= '0;
                        if (level_sel == LAST_LEVEL) begin
                            state   <= S_DONE;
                            flags_q <= flags_for(S_DONE);
                        end else begin
                            level_sel <= level_sel + 2'd1;
                            cyc_cnt   <= LOAD_INIT;
                            state     <= S_LOAD;
                            flags_q   <= flags_for(S_LOAD);
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
                S_LOSE_HOLD: begin
                    if (frame_done) begin
                        frame_cnt <= '0;
                        if (lives <= 4'd1) begin
                            lives   <= 4'd0;
                            state   <= S_OVER;
                            flags_q <= flags_for(S_OVER);
                        end else begin
                            lives   <= lives - 4'd1;
                            cyc_cnt <= LOAD_INIT;
                            state   <= S_LOAD;
                            flags_q <= flags_for(S_LOAD);
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
                S_OVER, S_DONE: begin
                    if (start_edge) begin
                        frame_cnt <= '0;
                        state     <= S_IDLE;
                        flags_q   <= flags_for(S_IDLE);
                    end
                end
                default: begin
                    frame_cnt <= '0;
                    state     <= S_IDLE;
                    flags_q   <= flags_for(S_IDLE);
                end
            endcase
        end
    end

endmodule
